// File: rtl/up_counter_pkg.sv
// Shared sizing and load constants for the serial byte collector.
package up_counter_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [WIDTH-1:0] RST_VAL = 8'h00;
  localparam logic [WIDTH-1:0] SET_VAL = 8'hFF;

endpackage

// File: rtl/up_counter_bit_counter.sv
// Bit counter for the byte collector: counts accepted bits modulo 2**CNT_W.
// tc flags the last bit position of a byte (count all ones).
module bit_counter
  import up_counter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  // Reset beats clear beats count; wrap to zero falls out of the natural overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  // Terminal count: the next enabled bit completes the byte.
  always_comb begin
    tc = &count;
  end

endmodule

// File: rtl/up_counter.sv
// Serial-in byte collector: shifts serin into an 8-bit register on each enabled
// clock and pulses Co on the clock that accepts the 8th bit of a byte.
module up_counter
  import up_counter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic             en,
  input  logic             serin,
  output logic [WIDTH-1:0] serout,
  output logic [CNT_W-1:0] cnen,
  output logic             Co
);

  logic tc;

  bit_counter u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (set),
    .en    (en),
    .count (cnen),
    .tc    (tc)
  );

  // Shift register: reset, preset (frame start), left shift of serin, or hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      serout <= RST_VAL;
    end else if (set) begin
      serout <= SET_VAL;
    end else if (en) begin
      serout <= {serout[WIDTH-2:0], serin};
    end
  end

  // Carry only when this edge really accepts the last bit; reset or set abort it.
  always_comb begin
    Co = rst & ~set & en & tc;
  end

endmodule

// File: tb/tb_up_counter.sv
// Self-checking bench for up_counter: table of vectors plus model-driven runs.
module tb_up_counter;
  import up_counter_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             set = 1'b0;
  logic             en = 1'b0;
  logic             serin = 1'b0;
  logic [WIDTH-1:0] serout;
  logic [CNT_W-1:0] cnen;
  logic             Co;

  up_counter dut (
    .clk    (clk),
    .rst    (rst),
    .set    (set),
    .en     (en),
    .serin  (serin),
    .serout (serout),
    .cnen   (cnen),
    .Co     (Co)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       r;
    logic       s;
    logic       e;
    logic       d;
    logic       xco;
    logic [7:0] xsr;
    logic [2:0] xcn;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(string n, logic r, logic s, logic e, logic d,
                              logic xco, logic [7:0] xsr, logic [2:0] xcn);
    vec_t v;
    v.name = n; v.r = r; v.s = s; v.e = e; v.d = d;
    v.xco = xco; v.xsr = xsr; v.xcn = xcn;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one clock of stimulus; Co checked before the edge, state after it.
  task automatic step(input vec_t v, output logic co_seen);
    vec_t h;
    @(negedge clk);
    rst = v.r; set = v.s; en = v.e; serin = v.d;
    exp_q.push_back(v);
    #1;
    co_seen = Co;
    check({v.name, "/Co"}, 32'(Co), 32'(v.xco));
    @(posedge clk);
    #1;
    h = exp_q.pop_front();
    check({h.name, "/serout"}, 32'(serout), 32'(h.xsr));
    check({h.name, "/cnen"}, 32'(cnen), 32'(h.xcn));
  endtask

  logic [7:0] m_sr;
  logic [2:0] m_cn;

  // Model-driven enabled shift; returns the observed Co.
  task automatic model_shift(input string n, input logic d, output logic co_seen);
    vec_t v;
    v = mk(n, 1'b1, 1'b0, 1'b1, d, (m_cn == 3'd7), {m_sr[6:0], d}, 3'(m_cn + 3'd1));
    m_sr = {m_sr[6:0], d};
    m_cn = 3'(m_cn + 3'd1);
    step(v, co_seen);
  endtask

  initial begin
    logic co;
    int   pulses;
    int   last_pulse;
    int   gap;
    logic prev_co;

    // 1: reset dominates regardless of other inputs
    tbl.push_back(mk("t1_rst_a", 0, 1, 1, 1, 0, 8'h00, 3'd0));
    tbl.push_back(mk("t1_rst_b", 0, 0, 1, 1, 0, 8'h00, 3'd0));
    // 2: preset then shift zeros
    tbl.push_back(mk("t2_set",   1, 1, 1, 0, 0, 8'hFF, 3'd0));
    tbl.push_back(mk("t2_sh1",   1, 0, 1, 0, 0, 8'hFE, 3'd1));
    tbl.push_back(mk("t2_sh2",   1, 0, 1, 0, 0, 8'hFC, 3'd2));
    tbl.push_back(mk("t2_sh3",   1, 0, 1, 0, 0, 8'hF8, 3'd3));
    // 3: full byte 1,0,1,1,0,0,1,0 from reset
    tbl.push_back(mk("t3_rst",   0, 0, 0, 0, 0, 8'h00, 3'd0));
    tbl.push_back(mk("t3_b0",    1, 0, 1, 1, 0, 8'h01, 3'd1));
    tbl.push_back(mk("t3_b1",    1, 0, 1, 0, 0, 8'h02, 3'd2));
    tbl.push_back(mk("t3_b2",    1, 0, 1, 1, 0, 8'h05, 3'd3));
    tbl.push_back(mk("t3_b3",    1, 0, 1, 1, 0, 8'h0B, 3'd4));
    tbl.push_back(mk("t3_b4",    1, 0, 1, 0, 0, 8'h16, 3'd5));
    tbl.push_back(mk("t3_b5",    1, 0, 1, 0, 0, 8'h2C, 3'd6));
    tbl.push_back(mk("t3_b6",    1, 0, 1, 1, 0, 8'h59, 3'd7));
    tbl.push_back(mk("t3_b7",    1, 0, 1, 0, 1, 8'hB2, 3'd0));
    // 5: enable toggling
    tbl.push_back(mk("t5_en1",   1, 0, 1, 1, 0, 8'h65, 3'd1));
    tbl.push_back(mk("t5_en0",   1, 0, 0, 0, 0, 8'h65, 3'd1));
    tbl.push_back(mk("t5_en1b",  1, 0, 1, 0, 0, 8'hCA, 3'd2));
    tbl.push_back(mk("t5_en0b",  1, 0, 0, 1, 0, 8'hCA, 3'd2));
    // 6: set wins at cnen=5, reset wins over set
    tbl.push_back(mk("t6_a",     1, 0, 1, 1, 0, 8'h95, 3'd3));
    tbl.push_back(mk("t6_b",     1, 0, 1, 1, 0, 8'h2B, 3'd4));
    tbl.push_back(mk("t6_c",     1, 0, 1, 0, 0, 8'h56, 3'd5));
    tbl.push_back(mk("t6_set",   1, 1, 1, 1, 0, 8'hFF, 3'd0));
    tbl.push_back(mk("t6_rst",   0, 1, 1, 1, 0, 8'h00, 3'd0));
    // Boundary at cnen=7: hold gives no Co, reset gives no Co
    tbl.push_back(mk("b7_1",     1, 0, 1, 1, 0, 8'h01, 3'd1));
    tbl.push_back(mk("b7_2",     1, 0, 1, 1, 0, 8'h03, 3'd2));
    tbl.push_back(mk("b7_3",     1, 0, 1, 1, 0, 8'h07, 3'd3));
    tbl.push_back(mk("b7_4",     1, 0, 1, 1, 0, 8'h0F, 3'd4));
    tbl.push_back(mk("b7_5",     1, 0, 1, 1, 0, 8'h1F, 3'd5));
    tbl.push_back(mk("b7_6",     1, 0, 1, 1, 0, 8'h3F, 3'd6));
    tbl.push_back(mk("b7_7",     1, 0, 1, 1, 0, 8'h7F, 3'd7));
    tbl.push_back(mk("b7_hold",  1, 0, 0, 0, 0, 8'h7F, 3'd7));
    tbl.push_back(mk("b7_rst",   0, 0, 1, 1, 0, 8'h00, 3'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], co);
    end

    // 4: 16 enabled clocks from reset -> two single-cycle Co pulses 8 apart
    step(mk("t4_rst", 0, 0, 0, 0, 0, 8'h00, 3'd0), co);
    m_sr = 8'h00;
    m_cn = 3'd0;
    pulses = 0;
    last_pulse = -1;
    gap = 0;
    prev_co = 1'b0;
    for (int i = 0; i < 16; i++) begin
      model_shift("t4_run", 1'($urandom_range(0, 1)), co);
      if (co) begin
        if (prev_co) check("t4_co_back_to_back", 32'(1), 32'(0));
        if (last_pulse >= 0) gap = i - last_pulse;
        last_pulse = i;
        pulses++;
      end
      prev_co = co;
    end
    check("t4_pulse_count", 32'(pulses), 32'(2));
    check("t4_pulse_gap", 32'(gap), 32'(8));
    check("t4_last_pulse_pos", 32'(last_pulse), 32'(15));

    // Set at cnen=7 aborts the byte with no Co
    for (int i = 0; i < 7; i++) begin
      model_shift("t7_fill", 1'($urandom_range(0, 1)), co);
    end
    check("t7_cnen_at_7", 32'(cnen), 32'(7));
    step(mk("t7_set_at_7", 1, 1, 1, 1, 0, 8'hFF, 3'd0), co);

    if (exp_q.size() != 0) check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
